tinker_run_monitor: RTL and testbench
=====================================

Name: tinker_run_monitor

Overview:
- Synthesizable run controller and monitor for tinker_core. It sequences the core's reset, counts cycles and retired instructions, detects halt, and enforces a watchdog timeout.
- It captures a circular trace of retired {PC, instruction} pairs that can be read back through a pop handshake.
- Sits beside tinker_core in the top-level harness. The bench observes and drains it instead of polling core internals.

Parameters:
- PC_W, 64, width of PC sample.
- INSTR_W, 32, width of instruction word.
- CNT_W, 32, width of cycle and retire counters.
- RESET_CYCLES, 1, cycles core_reset is held after a start (must be ≥1).
- MAX_CYCLES, 1000, watchdog limit in RUN cycles; 0 disables the watchdog.
- TRACE_DEPTH, 16, trace buffer entries (power of 2, ≥2).
- AUTO_START, 1, 1 = leave reset directly into RESET_HOLD; 0 = wait in IDLE for start.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; (re)starts a run.
- hlt_in  input  1  halt flag from tinker_core.
- instr_valid  input  1  an instruction retires this cycle.
- pc_in  input  PC_W  PC of retiring instruction.
- instr_in  input  INSTR_W  retiring instruction word.
- core_reset  output  1  reset to tinker_core.
- running  output  1  state == RUN.
- done  output  1  state is HALTED or TIMEOUT.
- halted  output  1  run ended by hlt_in.
- timed_out  output  1  run ended by watchdog.
- cycle_count  output  CNT_W  RUN cycles elapsed.
- retired_count  output  CNT_W  instructions retired this run.
- trace_rd_en  input  1  pop the oldest trace entry.
- trace_rd_valid  output  1  registered pulse: read data valid.
- trace_rd_pc  output  PC_W  popped PC.
- trace_rd_instr  output  INSTR_W  popped instruction.
- trace_count  output  $clog2(TRACE_DEPTH)+1  entries held.
- trace_overflow  output  1  sticky: an entry was overwritten.

Behaviour:
- States: IDLE, RESET_HOLD, RUN, HALTED, TIMEOUT.
- Reset values:
  - state = RESET_HOLD if AUTO_START, else IDLE.
  - core_reset = 1.
  - running, done, halted, timed_out, trace_rd_valid, trace_overflow = 0.
  - Counters = 0; trace empty; read data = 0.
  - Reset asserted mid-run aborts immediately with the same values.
- IDLE: core_reset = 1. start → RESET_HOLD.
- RESET_HOLD:
  - core_reset = 1 for exactly RESET_CYCLES cycles, then RUN.
  - Entry clears cycle_count, retired_count, trace (pointers, count) and trace_overflow.
- RUN: core_reset = 0, running = 1.
  - Each cycle, cycle_count increments, saturating at all-ones.
  - If instr_valid: retired_count increments (saturating) and {pc_in, instr_in} is pushed.
  - If hlt_in: → HALTED. A same-cycle instr_valid is still captured.
  - Else if MAX_CYCLES ≠ 0 and cycle_count == MAX_CYCLES-1: → TIMEOUT.
  - hlt_in and timeout in the same cycle: halt wins.
- HALTED/TIMEOUT:
  - done = 1; halted or timed_out = 1.
  - core_reset stays 0; counters frozen; no trace pushes.
- start in any non-IDLE state → RESET_HOLD (abort/restart); halted and timed_out clear. start outranks hlt_in and timeout in the same cycle.
- Trace buffer (circular):
  - Push when full overwrites the oldest entry; count stays TRACE_DEPTH; trace_overflow is set.
  - trace_rd_en with count > 0 pops the oldest. Data appears registered one cycle later with trace_rd_valid = 1 for one cycle.
  - trace_rd_en when empty is ignored (no valid pulse).
  - Push and pop in the same cycle when full: pop oldest, store new, count unchanged, no overflow.
  - Push and pop when 0 < count < DEPTH: count unchanged.
  - Reads are allowed in every state. A RESET_HOLD entry clears the buffer, and any in-flight valid pulse still completes.

Test Plan:
- Defaults; reset 2 cycles; drive 5 retires, then hlt_in at RUN cycle 7 → core_reset low from cycle after RESET_HOLD; halted = 1, done = 1, timed_out = 0; cycle_count = 8; retired_count = 5; trace_count = 5.
- MAX_CYCLES = 20, hlt_in never asserted → TIMEOUT after 20 RUN cycles; timed_out = 1, cycle_count = 20. Repeat with hlt_in on cycle 19 → halted = 1, timed_out = 0.
- TRACE_DEPTH = 4; retire PCs 0x00, 0x04, …, 0x14 (6 entries) → trace_overflow = 1, trace_count = 4; pops return 0x08, 0x0C, 0x10, 0x14, each with a 1-cycle trace_rd_valid; a 5th pop gives no valid pulse.
- Buffer full (4); same-cycle push PC 0x18 and pop → popped PC 0x08; count stays 4; overflow unchanged.
- AUTO_START = 0 → core_reset stays 1 with no start. start pulse → RESET_HOLD; RESET_CYCLES = 3 gives exactly 3 cycles of core_reset before running = 1.
- start pulse mid-RUN at cycle 10 with 3 entries traced → counters and trace_count = 0, core_reset = 1 for RESET_CYCLES; assert reset mid-RUN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/tinker_run_monitor.sv
// ---------------------------------------------------------------------------
// tinker_run_monitor
//
// Run controller and monitor that sits beside tinker_core. It sequences the
// core reset, counts RUN cycles and retired instructions, stops on halt or on
// a watchdog timeout, and keeps a circular trace of retired {PC, instruction}
// pairs that can be drained through a pop handshake.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   start          one-cycle pulse, (re)starts a run from any state
//   hlt_in         halt flag from the core
//   instr_valid    an instruction retires this cycle
//   pc_in          PC of the retiring instruction
//   instr_in       retiring instruction word
//   core_reset     reset to the core (high in IDLE and RESET_HOLD)
//   running        state is RUN
//   done           state is HALTED or TIMEOUT
//   halted         run ended by hlt_in
//   timed_out      run ended by the watchdog
//   cycle_count    RUN cycles elapsed (saturating)
//   retired_count  instructions retired this run (saturating)
//   trace_rd_en    pop the oldest trace entry
//   trace_rd_valid registered one-cycle pulse: read data valid
//   trace_rd_pc    popped PC
//   trace_rd_instr popped instruction
//   trace_count    entries currently held
//   trace_overflow sticky: an entry was overwritten
// ---------------------------------------------------------------------------
module tinker_run_monitor #(
    parameter int PC_W         = 64,
    parameter int INSTR_W      = 32,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 1000,
    parameter int TRACE_DEPTH  = 16,
    parameter int AUTO_START   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           hlt_in,
    input  logic                           instr_valid,
    input  logic [PC_W-1:0]                pc_in,
    input  logic [INSTR_W-1:0]             instr_in,
    output logic                           core_reset,
    output logic                           running,
    output logic                           done,
    output logic                           halted,
    output logic                           timed_out,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               retired_count,
    input  logic                           trace_rd_en,
    output logic                           trace_rd_valid,
    output logic [PC_W-1:0]                trace_rd_pc,
    output logic [INSTR_W-1:0]             trace_rd_instr,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int EW = PC_W + INSTR_W;

    typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, HALTED, TIMEOUT} state_t;

    state_t             state_reg, state_next;
    logic [HW-1:0]      hold_reg;
    logic [CNT_W-1:0]   cycle_reg, retired_reg;
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               overflow_reg;
    logic               rd_valid_reg;
    logic [PC_W-1:0]    rd_pc_reg;
    logic [INSTR_W-1:0] rd_instr_reg;
    logic [EW-1:0]      trace_mem [TRACE_DEPTH];

    logic hold_done, watchdog_hit, full, push, pop;

    assign hold_done = (hold_reg == HW'(RESET_CYCLES - 1));
    assign full      = (count_reg == CW'(TRACE_DEPTH));
    // A start in RUN aborts the run, so the same-cycle retire is not traced.
    assign push      = (state_reg == RUN) && instr_valid && !start;
    assign pop       = trace_rd_en && (count_reg != '0);

    generate
        if (MAX_CYCLES != 0) begin : g_watchdog
            assign watchdog_hit = (cycle_reg == CNT_W'(MAX_CYCLES - 1));
        end else begin : g_no_watchdog
            assign watchdog_hit = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= (AUTO_START != 0) ? RESET_HOLD : IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start outranks halt, halt outranks the watchdog.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (start) state_next = RESET_HOLD;
            RESET_HOLD: if (start) state_next = RESET_HOLD;
                        else if (hold_done) state_next = RUN;
            RUN:        if (start) state_next = RESET_HOLD;
                        else if (hlt_in) state_next = HALTED;
                        else if (watchdog_hit) state_next = TIMEOUT;
            HALTED,
            TIMEOUT:    if (start) state_next = RESET_HOLD;
            default:    state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        core_reset = (state_reg == IDLE) || (state_reg == RESET_HOLD);
        running    = (state_reg == RUN);
        halted     = (state_reg == HALTED);
        timed_out  = (state_reg == TIMEOUT);
        done       = halted || timed_out;
    end

    // Hold timer, counters and trace pointers. Every start re-enters
    // RESET_HOLD, so start alone is the "entry" condition that clears a run.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            hold_reg     <= '0;
            cycle_reg    <= '0;
            retired_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (state_reg == RESET_HOLD && !hold_done) begin
                hold_reg <= hold_reg + 1'b1;
            end
            if (state_reg == RUN) begin
                if (cycle_reg != '1) begin
                    cycle_reg <= cycle_reg + 1'b1;
                end
                if (instr_valid && retired_reg != '1) begin
                    retired_reg <= retired_reg + 1'b1;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            // When full, the write slot equals the oldest slot, so a push
            // alone must also drop the oldest entry.
            if (pop || (push && full)) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop && full) begin
                overflow_reg <= 1'b1;
            end
            if (push && !pop && !full) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Trace storage: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            trace_mem[wr_ptr_reg] <= {pc_in, instr_in};
        end
    end

    // Registered read port. The read sees the pre-write contents, so a
    // full-buffer push+pop returns the oldest entry, not the new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_pc_reg    <= '0;
            rd_instr_reg <= '0;
        end else begin
            rd_valid_reg <= pop;
            if (pop) begin
                {rd_pc_reg, rd_instr_reg} <= trace_mem[rd_ptr_reg];
            end
        end
    end

    assign cycle_count    = cycle_reg;
    assign retired_count  = retired_reg;
    assign trace_rd_valid = rd_valid_reg;
    assign trace_rd_pc    = rd_pc_reg;
    assign trace_rd_instr = rd_instr_reg;
    assign trace_count    = count_reg;
    assign trace_overflow = overflow_reg;

endmodule

// File: tb/tb_tinker_run_monitor.sv
module tb_tinker_run_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // DUT A: default parameters
    logic        a_reset = 1'b1, a_start = 1'b0, a_hlt = 1'b0, a_iv = 1'b0, a_rd_en = 1'b0;
    logic [63:0] a_pc = '0;
    logic [31:0] a_instr = '0;
    logic        a_core_reset, a_running, a_done, a_halted, a_timed_out;
    logic [31:0] a_cycle, a_retired;
    logic        a_rd_valid, a_overflow;
    logic [63:0] a_rd_pc;
    logic [31:0] a_rd_instr;
    logic [4:0]  a_count;

    tinker_run_monitor u_dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .hlt_in(a_hlt),
        .instr_valid(a_iv), .pc_in(a_pc), .instr_in(a_instr),
        .core_reset(a_core_reset), .running(a_running), .done(a_done),
        .halted(a_halted), .timed_out(a_timed_out),
        .cycle_count(a_cycle), .retired_count(a_retired),
        .trace_rd_en(a_rd_en), .trace_rd_valid(a_rd_valid),
        .trace_rd_pc(a_rd_pc), .trace_rd_instr(a_rd_instr),
        .trace_count(a_count), .trace_overflow(a_overflow)
    );

    // DUT B: small watchdog, small trace, manual start, long reset hold
    logic        b_reset = 1'b1, b_start = 1'b0, b_hlt = 1'b0, b_iv = 1'b0, b_rd_en = 1'b0;
    logic [63:0] b_pc = '0;
    logic [31:0] b_instr = '0;
    logic        b_core_reset, b_running, b_done, b_halted, b_timed_out;
    logic [31:0] b_cycle, b_retired;
    logic        b_rd_valid, b_overflow;
    logic [63:0] b_rd_pc;
    logic [31:0] b_rd_instr;
    logic [2:0]  b_count;

    tinker_run_monitor #(
        .RESET_CYCLES(3), .MAX_CYCLES(20), .TRACE_DEPTH(4), .AUTO_START(0)
    ) u_dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .hlt_in(b_hlt),
        .instr_valid(b_iv), .pc_in(b_pc), .instr_in(b_instr),
        .core_reset(b_core_reset), .running(b_running), .done(b_done),
        .halted(b_halted), .timed_out(b_timed_out),
        .cycle_count(b_cycle), .retired_count(b_retired),
        .trace_rd_en(b_rd_en), .trace_rd_valid(b_rd_valid),
        .trace_rd_pc(b_rd_pc), .trace_rd_instr(b_rd_instr),
        .trace_count(b_count), .trace_overflow(b_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop one entry from DUT B and check the one-cycle valid pulse and data.
    task automatic pop_b(input string tag, input logic [63:0] exp_pc);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        $display("[TB] %s pop valid=%0b pc=%0h", tag, b_rd_valid, b_rd_pc);
        check({tag, "_valid"}, 64'(b_rd_valid), 64'd1);
        check({tag, "_pc"}, b_rd_pc, exp_pc);
        check({tag, "_instr"}, 64'(b_rd_instr), 64'(32'hA000_0000 | 32'(exp_pc)));
        tick();
        check({tag, "_valid_drop"}, 64'(b_rd_valid), 64'd0);
    endtask

    initial begin
        int n;
        int cyc;

        // ---------------- DUT A: halt run ----------------
        tick(); tick();
        check("a_rst_core_reset", 64'(a_core_reset), 64'd1);
        check("a_rst_running", 64'(a_running), 64'd0);
        check("a_rst_done", 64'(a_done), 64'd0);
        check("a_rst_cycle", 64'(a_cycle), 64'd0);
        check("a_rst_count", 64'(a_count), 64'd0);
        check("a_rst_rd_valid", 64'(a_rd_valid), 64'd0);
        a_reset = 1'b0;
        tick();
        check("a_run_after_hold", 64'(a_running), 64'd1);
        check("a_core_reset_low", 64'(a_core_reset), 64'd0);
        for (int c = 0; c < 8; c++) begin
            a_iv    = (c < 5);
            a_pc    = 64'(c * 4);
            a_instr = 32'hA000_0000 | 32'(c * 4);
            a_hlt   = (c == 7);
            tick();
        end
        a_iv = 1'b0; a_hlt = 1'b0;
        $display("[TB] A halt: cycle=%0d retired=%0d count=%0d", a_cycle, a_retired, a_count);
        check("a_halted", 64'(a_halted), 64'd1);
        check("a_done", 64'(a_done), 64'd1);
        check("a_timed_out", 64'(a_timed_out), 64'd0);
        check("a_cycle", 64'(a_cycle), 64'd8);
        check("a_retired", 64'(a_retired), 64'd5);
        check("a_count", 64'(a_count), 64'd5);
        tick(); tick();
        check("a_cycle_frozen", 64'(a_cycle), 64'd8);
        check("a_core_reset_halted", 64'(a_core_reset), 64'd0);
        for (int i = 0; i < 5; i++) begin
            a_rd_en = 1'b1;
            tick();
            a_rd_en = 1'b0;
            $display("[TB] A pop valid=%0b pc=%0h", a_rd_valid, a_rd_pc);
            check("a_pop_valid", 64'(a_rd_valid), 64'd1);
            check("a_pop_pc", a_rd_pc, 64'(i * 4));
        end
        tick();
        check("a_pop_idle", 64'(a_rd_valid), 64'd0);
        check("a_count_empty", 64'(a_count), 64'd0);

        // restart from HALTED
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_restart_core_reset", 64'(a_core_reset), 64'd1);
        check("a_restart_halted_clr", 64'(a_halted), 64'd0);
        check("a_restart_cycle", 64'(a_cycle), 64'd0);
        check("a_restart_retired", 64'(a_retired), 64'd0);
        tick();
        check("a_restart_running", 64'(a_running), 64'd1);

        // start mid-RUN at cycle 10 with 3 entries traced
        for (int c = 0; c <= 10; c++) begin
            a_iv    = (c < 3);
            a_pc    = 64'(32'h20 + c * 4);
            a_instr = 32'hA000_0000 | 32'(32'h20 + c * 4);
            a_start = (c == 10);
            if (c == 10) begin
                check("a_mid_cycle_before", 64'(a_cycle), 64'd10);
                check("a_mid_count_before", 64'(a_count), 64'd3);
            end
            tick();
        end
        a_iv = 1'b0; a_start = 1'b0;
        check("a_mid_core_reset", 64'(a_core_reset), 64'd1);
        check("a_mid_running", 64'(a_running), 64'd0);
        check("a_mid_cycle", 64'(a_cycle), 64'd0);
        check("a_mid_retired", 64'(a_retired), 64'd0);
        check("a_mid_count", 64'(a_count), 64'd0);
        tick();
        check("a_mid_rerun", 64'(a_running), 64'd1);
        for (int c = 0; c < 3; c++) begin
            a_iv    = 1'b1;
            a_pc    = 64'(32'h40 + c * 4);
            a_instr = 32'hA000_0000 | 32'(32'h40 + c * 4);
            a_rd_en = (c == 2);
            tick();
        end
        a_iv = 1'b0; a_rd_en = 1'b0;
        check("a_pushpop_pc", a_rd_pc, 64'h40);
        check("a_pushpop_count", 64'(a_count), 64'd2);
        // reset mid-RUN
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check("a_mrst_core_reset", 64'(a_core_reset), 64'd1);
        check("a_mrst_running", 64'(a_running), 64'd0);
        check("a_mrst_cycle", 64'(a_cycle), 64'd0);
        check("a_mrst_retired", 64'(a_retired), 64'd0);
        check("a_mrst_count", 64'(a_count), 64'd0);
        check("a_mrst_rd_valid", 64'(a_rd_valid), 64'd0);
        check("a_mrst_rd_pc", a_rd_pc, 64'd0);

        // ---------------- DUT B: manual start, timeout, small trace ----------------
        b_reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("b_idle_core_reset", 64'(b_core_reset), 64'd1);
        check("b_idle_running", 64'(b_running), 64'd0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (b_core_reset && n < 10) begin
            n++;
            tick();
        end
        check("b_hold_cycles", 64'(n), 64'd3);
        check("b_running", 64'(b_running), 64'd1);

        cyc = 0;
        while (!b_done && cyc < 30) begin
            b_iv    = (cyc < 6);
            b_pc    = 64'(cyc * 4);
            b_instr = 32'hA000_0000 | 32'(cyc * 4);
            tick();
            cyc++;
        end
        b_iv = 1'b0;
        $display("[TB] B timeout after %0d cycles, cycle_count=%0d", cyc, b_cycle);
        check("b_timeout_cycles", 64'(cyc), 64'd20);
        check("b_timed_out", 64'(b_timed_out), 64'd1);
        check("b_to_halted", 64'(b_halted), 64'd0);
        check("b_to_cycle", 64'(b_cycle), 64'd20);
        check("b_to_retired", 64'(b_retired), 64'd6);
        check("b_to_count", 64'(b_count), 64'd4);
        check("b_to_overflow", 64'(b_overflow), 64'd1);
        pop_b("b_p0", 64'h08);
        pop_b("b_p1", 64'h0C);
        pop_b("b_p2", 64'h10);
        pop_b("b_p3", 64'h14);
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        check("b_p4_empty", 64'(b_rd_valid), 64'd0);

        // restart, fill, same-cycle push+pop when full, halt at cycle 19
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_restart_overflow", 64'(b_overflow), 64'd0);
        check("b_restart_timed_out", 64'(b_timed_out), 64'd0);
        tick(); tick(); tick();
        check("b_rerun", 64'(b_running), 64'd1);
        for (int c = 0; c < 20; c++) begin
            b_iv    = (c <= 6);
            b_pc    = 64'(c * 4);
            b_instr = 32'hA000_0000 | 32'(c * 4);
            b_rd_en = (c == 6);
            b_hlt   = (c == 19);
            tick();
            if (c == 6) begin
                $display("[TB] B push+pop valid=%0b pc=%0h count=%0d", b_rd_valid, b_rd_pc, b_count);
                check("b_pp_valid", 64'(b_rd_valid), 64'd1);
                check("b_pp_pc", b_rd_pc, 64'h08);
                check("b_pp_count", 64'(b_count), 64'd4);
                check("b_pp_overflow", 64'(b_overflow), 64'd1);
            end
        end
        b_iv = 1'b0; b_rd_en = 1'b0; b_hlt = 1'b0;
        check("b_h19_halted", 64'(b_halted), 64'd1);
        check("b_h19_timed_out", 64'(b_timed_out), 64'd0);
        check("b_h19_cycle", 64'(b_cycle), 64'd20);
        pop_b("b_q0", 64'h0C);
        pop_b("b_q1", 64'h10);
        pop_b("b_q2", 64'h14);
        pop_b("b_q3", 64'h18);
        check("b_q_empty", 64'(b_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
